blackjack_engine: RTL and testbench



---
 rtl/blackjack_pkg.sv | 85 ++++++++
 rtl/card_source.sv | 45 ++++
 rtl/blackjack_engine.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_blackjack_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_pkg
//
// Shared definitions for the blackjack round controller:
//   - FSM state encoding (state_t / ST_* constants)
//   - per-player result codes (RES_NONE / RES_WIN / RES_LOSE / RES_PUSH)
//   - hand_add(): saturating hand-total addition. When BLACKJACK_SOFT_ACE_EN
//     is defined it also performs the soft-ace promotion/demotion and returns
//     the updated soft flag alongside the total.
//
// Configuration macro: BLACKJACK_SOFT_ACE_EN (undefined -> aces always 1).
// ---------------------------------------------------------------------------
package blackjack_pkg;

   // Internal arithmetic width of hand_add; callers zero-extend into it and
   // truncate the saturated result back to their own total width.
   localparam int SUM_W = 16;

   typedef logic [SUM_W-1:0] sum_t;
   typedef logic [SUM_W:0]   wide_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE        = 3'd0;
   localparam state_t ST_DEAL        = 3'd1;
   localparam state_t ST_PLAYER_TURN = 3'd2;
   localparam state_t ST_DEALER_TURN = 3'd3;
   localparam state_t ST_SCORE       = 3'd4;
   localparam state_t ST_DONE        = 3'd5;

   typedef logic [1:0] result_t;
   localparam result_t RES_NONE = 2'b00;
   localparam result_t RES_WIN  = 2'b01;
   localparam result_t RES_LOSE = 2'b10;
   localparam result_t RES_PUSH = 2'b11;

`ifdef BLACKJACK_SOFT_ACE_EN
   typedef struct packed {
      logic soft;
      sum_t total;
   } hand_t;

   // An ace is promoted to 11 only when that cannot bust the hand. A soft
   // hand that goes over the limit is demoted by 10 in the same addition, so
   // the caller never sees a transient busted soft total.
   function automatic hand_t hand_add(input sum_t total, input logic soft,
                                      input sum_t card, input sum_t bust_limit,
                                      input sum_t max_total);
      wide_t sum;
      sum_t  value;
      hand_t r;
      value  = card;
      r.soft = soft;
      if (card == sum_t'(1) && ({1'b0, total} + wide_t'(11) <= {1'b0, bust_limit})) begin
         value  = sum_t'(11);
         r.soft = 1'b1;
      end
      sum = {1'b0, total} + {1'b0, value};
      if (r.soft && sum > {1'b0, bust_limit}) begin
         sum    = sum - wide_t'(10);
         r.soft = 1'b0;
      end
      if (sum > {1'b0, max_total}) begin
         sum = {1'b0, max_total};
      end
      r.total = sum[SUM_W-1:0];
      return r;
   endfunction
`else
   // Plain saturating add: totals stick at max_total instead of wrapping.
   function automatic sum_t hand_add(input sum_t total, input sum_t card,
                                     input sum_t bust_limit, input sum_t max_total);
      wide_t sum;
      sum = {1'b0, total} + {1'b0, card};
      if (sum > {1'b0, max_total}) begin
         sum = {1'b0, max_total};
      end
      // bust_limit only matters for the soft-ace adjustment
      if (bust_limit > max_total) begin
         sum = {1'b0, max_total};
      end
      return sum[SUM_W-1:0];
   endfunction
`endif

endpackage

// File: rtl/card_source.sv
// ---------------------------------------------------------------------------
// card_source
//
// Free-running card generator: counts 1, 2, ..., CARD_MAX, 1, ... advancing
// every clock. The card dealt in a cycle is the value held in that cycle.
//
// Ports:
//   Clock  in   system clock
//   reset  in   synchronous active-high reset, loads the counter with 1
//   card   out  current card value (1..CARD_MAX)
// ---------------------------------------------------------------------------
module card_source
   import blackjack_pkg::*;
#(
   parameter  int CARD_MAX = 10,
   localparam int CARD_W   = $clog2(CARD_MAX + 1)
) (
   input  logic              Clock,
   input  logic              reset,
   output logic [CARD_W-1:0] card
);

   logic [CARD_W-1:0] card_q;
   logic [CARD_W-1:0] card_d;

   // Wrap back to 1 at the top; >= also recovers from any stray value.
   always_comb begin
      if (card_q >= CARD_W'(CARD_MAX)) begin
         card_d = CARD_W'(1);
      end else begin
         card_d = card_q + CARD_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         card_q <= CARD_W'(1);
      end else begin
         card_q <= card_d;
      end
   end

   assign card = card_q;

endmodule

// File: rtl/blackjack_engine.sv
// ---------------------------------------------------------------------------
// blackjack_engine
//
// Multi-player blackjack round controller. Deals from an internal
// card_source, runs player turns (hit/stand), the dealer turn and scoring,
// and presents every hand total plus a per-player result.
//
// Ports:
//   Clock          in   system clock
//   reset          in   synchronous active-high reset (aborts any round)
//   start          in   level; rising edge starts a round from IDLE/DONE
//   hit            in   level; rising edge draws a card for the active player
//   stand          in   level; rising edge ends the active player's turn
//   phand          out  player totals, player i at [i*SCORE_W +: SCORE_W]
//   dhand          out  dealer total
//   active_player  out  index of the player whose turn it is
//   result         out  2 bits per player: 00 none, 01 win, 10 lose, 11 push
//   done           out  high while result is valid
//
// Configuration macro: BLACKJACK_SOFT_ACE_EN enables soft-ace handling
// (ace counts 11 when safe, demoted to 1 on a later bust).
// ---------------------------------------------------------------------------
module blackjack_engine
   import blackjack_pkg::*;
#(
   parameter  int NUM_PLAYERS  = 2,
   parameter  int SCORE_W      = 5,
   parameter  int CARD_MAX     = 10,
   parameter  int DEALER_STAND = 17,
   parameter  int BUST_LIMIT   = 21,
   localparam int AP_W         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           Clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           hit,
   input  logic                           stand,
   output logic [NUM_PLAYERS*SCORE_W-1:0] phand,
   output logic [SCORE_W-1:0]             dhand,
   output logic [AP_W-1:0]                active_player,
   output logic [2*NUM_PLAYERS-1:0]       result,
   output logic                           done
);

   localparam int CARD_W    = $clog2(CARD_MAX + 1);
   localparam int DEAL_W    = $clog2(2 * NUM_PLAYERS + 1);
   localparam int MAX_TOTAL = (2 ** SCORE_W) - 1;

   localparam logic [SCORE_W-1:0] BUST_S  = SCORE_W'(BUST_LIMIT);
   localparam logic [SCORE_W-1:0] STAND_S = SCORE_W'(DEALER_STAND);
   localparam logic [DEAL_W-1:0]  DEAL_LAST = DEAL_W'(2 * NUM_PLAYERS);
   localparam logic [AP_W-1:0]    LAST_P  = AP_W'(NUM_PLAYERS - 1);

   // Parameter sanity: totals must be able to represent the worst bust.
   if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
      $error("blackjack_engine: NUM_PLAYERS must be 1..4");
   end
   if (BUST_LIMIT + CARD_MAX > MAX_TOTAL) begin : g_bad_width
      $error("blackjack_engine: SCORE_W too narrow for BUST_LIMIT+CARD_MAX");
   end
   if (SCORE_W > SUM_W) begin : g_bad_sum
      $error("blackjack_engine: SCORE_W exceeds hand_add width");
   end

   logic [CARD_W-1:0] card;

   card_source #(.CARD_MAX(CARD_MAX)) u_card_source (
      .Clock (Clock),
      .reset (reset),
      .card  (card)
   );

   state_t                    state_q, state_d;
   logic [DEAL_W-1:0]         deal_cnt_q, deal_cnt_d;
   logic [AP_W-1:0]           active_player_q, active_player_d;
   logic [SCORE_W-1:0]        p_total_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]        p_total_d [NUM_PLAYERS];
   logic [SCORE_W-1:0]        dhand_q, dhand_d;
   logic [2*NUM_PLAYERS-1:0]  result_q, result_d;
   logic                      done_q, done_d;
   logic [2:0]                in_prev_q, in_prev_d;
`ifdef BLACKJACK_SOFT_ACE_EN
   logic                      p_soft_q [NUM_PLAYERS];
   logic                      p_soft_d [NUM_PLAYERS];
   logic                      d_soft_q, d_soft_d;
   logic                      add_in_soft;
   logic                      add_soft;
   hand_t                     add_res;
`endif

   logic                      start_edge, hit_edge, stand_edge;
   logic                      sel_dealer;
   logic [AP_W-1:0]           sel_player;
   logic [SCORE_W-1:0]        add_in_total;
   logic [SCORE_W-1:0]        add_total;
   logic                      advance;
   logic                      all_bust;
   logic                      dealer_bust;

   // Edge detection: previous level of {stand, hit, start}.
   always_comb begin
      in_prev_d  = {stand, hit, start};
      start_edge = start & ~in_prev_q[0];
      hit_edge   = hit   & ~in_prev_q[1];
      stand_edge = stand & ~in_prev_q[2];
   end

   // At most one hand receives a card per cycle, so a single adder serves the
   // deal, player hits and dealer draws. This block picks which hand feeds it.
   always_comb begin
      sel_dealer = 1'b1;
      sel_player = '0;
      if (state_q == ST_DEAL && deal_cnt_q < DEAL_LAST) begin
         sel_dealer = 1'b0;
         if (deal_cnt_q < DEAL_W'(NUM_PLAYERS)) begin
            sel_player = AP_W'(deal_cnt_q);
         end else begin
            sel_player = AP_W'(deal_cnt_q - DEAL_W'(NUM_PLAYERS));
         end
      end else if (state_q == ST_PLAYER_TURN) begin
         sel_dealer = 1'b0;
         sel_player = active_player_q;
      end
      add_in_total = dhand_q;
`ifdef BLACKJACK_SOFT_ACE_EN
      add_in_soft = d_soft_q;
`endif
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (!sel_dealer && sel_player == AP_W'(i)) begin
            add_in_total = p_total_q[i];
`ifdef BLACKJACK_SOFT_ACE_EN
            add_in_soft = p_soft_q[i];
`endif
         end
      end
   end

`ifdef BLACKJACK_SOFT_ACE_EN
   always_comb begin
      add_res   = hand_add(sum_t'(add_in_total), add_in_soft, sum_t'(card),
                           sum_t'(BUST_LIMIT), sum_t'(MAX_TOTAL));
      add_total = SCORE_W'(add_res.total);
      add_soft  = add_res.soft;
   end
`else
   assign add_total = SCORE_W'(hand_add(sum_t'(add_in_total), sum_t'(card),
                                        sum_t'(BUST_LIMIT), sum_t'(MAX_TOTAL)));
`endif

   // Round FSM. Hands, result and done are held everywhere except where a
   // state explicitly writes them; DONE keeps the finished round on display.
   // With soft aces the total already counts the ace as 11, so comparing the
   // total against DEALER_STAND makes the dealer stand on soft 17.
   always_comb begin
      state_d         = state_q;
      deal_cnt_d      = deal_cnt_q;
      active_player_d = active_player_q;
      dhand_d         = dhand_q;
      result_d        = result_q;
      done_d          = done_q;
      advance         = 1'b0;
      all_bust        = 1'b1;
      dealer_bust     = (dhand_q > BUST_S);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         p_total_d[i] = p_total_q[i];
         if (p_total_q[i] <= BUST_S) begin
            all_bust = 1'b0;
         end
      end
`ifdef BLACKJACK_SOFT_ACE_EN
      d_soft_d = d_soft_q;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         p_soft_d[i] = p_soft_q[i];
      end
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_edge) begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  p_total_d[i] = '0;
`ifdef BLACKJACK_SOFT_ACE_EN
                  p_soft_d[i] = 1'b0;
`endif
               end
`ifdef BLACKJACK_SOFT_ACE_EN
               d_soft_d = 1'b0;
`endif
               dhand_d         = '0;
               result_d        = '0;
               done_d          = 1'b0;
               deal_cnt_d      = '0;
               active_player_d = '0;
               state_d         = ST_DEAL;
            end
         end

         ST_DEAL: begin
            if (sel_dealer) begin
               dhand_d = add_total;
`ifdef BLACKJACK_SOFT_ACE_EN
               d_soft_d = add_soft;
`endif
            end else begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (sel_player == AP_W'(i)) begin
                     p_total_d[i] = add_total;
`ifdef BLACKJACK_SOFT_ACE_EN
                     p_soft_d[i] = add_soft;
`endif
                  end
               end
            end
            if (deal_cnt_q == DEAL_LAST) begin
               deal_cnt_d      = '0;
               active_player_d = '0;
               state_d         = ST_PLAYER_TURN;
            end else begin
               deal_cnt_d = deal_cnt_q + DEAL_W'(1);
            end
         end

         ST_PLAYER_TURN: begin
            // stand takes priority over a simultaneous hit
            if (stand_edge) begin
               advance = 1'b1;
            end else if (hit_edge) begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (active_player_q == AP_W'(i)) begin
                     p_total_d[i] = add_total;
`ifdef BLACKJACK_SOFT_ACE_EN
                     p_soft_d[i] = add_soft;
`endif
                  end
               end
               if (add_total > BUST_S) begin
                  advance = 1'b1;
               end
            end
            if (advance) begin
               if (active_player_q == LAST_P) begin
                  state_d = ST_DEALER_TURN;
               end else begin
                  active_player_d = active_player_q + AP_W'(1);
               end
            end
         end

         ST_DEALER_TURN: begin
            if (all_bust) begin
               state_d = ST_SCORE;
            end else if (dhand_q < STAND_S) begin
               dhand_d = add_total;
`ifdef BLACKJACK_SOFT_ACE_EN
               d_soft_d = add_soft;
`endif
            end else begin
               state_d = ST_SCORE;
            end
         end

         ST_SCORE: begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               if (p_total_q[i] > BUST_S) begin
                  result_d[2*i +: 2] = RES_LOSE;
               end else if (dealer_bust) begin
                  result_d[2*i +: 2] = RES_WIN;
               end else if (p_total_q[i] > dhand_q) begin
                  result_d[2*i +: 2] = RES_WIN;
               end else if (p_total_q[i] == dhand_q) begin
                  result_d[2*i +: 2] = RES_PUSH;
               end else begin
                  result_d[2*i +: 2] = RES_LOSE;
               end
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         deal_cnt_q      <= '0;
         active_player_q <= '0;
         dhand_q         <= '0;
         result_q        <= '0;
         done_q          <= 1'b0;
         in_prev_q       <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            p_total_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         deal_cnt_q      <= deal_cnt_d;
         active_player_q <= active_player_d;
         dhand_q         <= dhand_d;
         result_q        <= result_d;
         done_q          <= done_d;
         in_prev_q       <= in_prev_d;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            p_total_q[i] <= p_total_d[i];
         end
      end
   end

`ifdef BLACKJACK_SOFT_ACE_EN
   always_ff @(posedge Clock) begin
      if (reset) begin
         d_soft_q <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            p_soft_q[i] <= 1'b0;
         end
      end else begin
         d_soft_q <= d_soft_d;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            p_soft_q[i] <= p_soft_d[i];
         end
      end
   end
`endif

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
      assign phand[g*SCORE_W +: SCORE_W] = p_total_q[g];
   end

   assign dhand         = dhand_q;
   assign active_player = active_player_q;
   assign result        = result_q;
   assign done          = done_q;

endmodule

// File: tb/tb_blackjack_engine.sv
// ---------------------------------------------------------------------------
// tb_blackjack_engine
//
// Directed bench for blackjack_engine (NUM_PLAYERS=2, default parameters).
// A model of the free-running card counter lets each scenario raise
// start/hit/stand in the exact cycle where a chosen card is on offer, so
// all expected totals and results are worked out by hand.
// Honours BLACKJACK_SOFT_ACE_EN for the soft-ace expectations.
// ---------------------------------------------------------------------------
module tb_blackjack_engine;

   logic       Clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       hit   = 1'b0;
   logic       stand = 1'b0;
   logic [9:0] phand;
   logic [4:0] dhand;
   logic [0:0] active_player;
   logic [3:0] result;
   logic       done;

   int total = 0;
   int bad   = 0;
   int tb_card = 0;

   blackjack_engine #(
      .NUM_PLAYERS  (2),
      .SCORE_W      (5),
      .CARD_MAX     (10),
      .DEALER_STAND (17),
      .BUST_LIMIT   (21)
   ) dut (
      .Clock         (Clock),
      .reset         (reset),
      .start         (start),
      .hit           (hit),
      .stand         (stand),
      .phand         (phand),
      .dhand         (dhand),
      .active_player (active_player),
      .result        (result),
      .done          (done)
   );

   always #5 Clock = ~Clock;

   // Reference card counter: 1 after reset, then 2..10, 1, ...
   always @(posedge Clock) begin
      if (reset) tb_card <= 1;
      else if (tb_card == 10) tb_card <= 1;
      else tb_card <= tb_card + 1;
   end

   // Waits (at negedges) for the cycle offering card v, raises the chosen
   // inputs for that one cycle, and returns at the following negedge.
   task automatic pulse_at(input int v, input logic s_start, input logic s_hit, input logic s_stand);
      int n;
      n = 0;
      while (tb_card != v && n < 25) begin
         @(negedge Clock);
         n++;
      end
      if (tb_card != v) begin
         bad++;
         $display("[TB] FAIL pulse_wait card=%0d required=%0d", tb_card, v);
      end
      start = s_start;
      hit   = s_hit;
      stand = s_stand;
      @(negedge Clock);
      start = 1'b0;
      hit   = 1'b0;
      stand = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clock);
      total++; if (phand !== 10'd0) begin bad++; $display("[TB] FAIL reset_phand got=%0d want=0", phand); end
      total++; if (dhand !== 5'd0) begin bad++; $display("[TB] FAIL reset_dhand got=%0d want=0", dhand); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%0d want=0", active_player); end
      total++; if (result !== 4'b0000) begin bad++; $display("[TB] FAIL reset_result got=%b want=0000", result); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      reset = 1'b0;
   endtask

   // Start at card 3: deal 4,5,6,7,8 -> P0=4+6, P1=5+7, dealer=8.
   task automatic test_deal();
      pulse_at(3, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge Clock);
      total++; if (phand[4:0] !== 5'd10) begin bad++; $display("[TB] FAIL deal_p0 got=%0d want=10", phand[4:0]); end
      total++; if (phand[9:5] !== 5'd12) begin bad++; $display("[TB] FAIL deal_p1 got=%0d want=12", phand[9:5]); end
      total++; if (dhand !== 5'd8) begin bad++; $display("[TB] FAIL deal_dealer got=%0d want=8", dhand); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL deal_active got=%0d want=0", active_player); end
   endtask

   // Both stand; P1's stand at card 8 puts the dealer turn on card 9 -> 17.
   task automatic test_dealer_draw();
      int k;
      pulse_at(10, 1'b0, 1'b0, 1'b1);
      total++; if (active_player !== 1'b1) begin bad++; $display("[TB] FAIL stand_advance got=%0d want=1", active_player); end
      pulse_at(8, 1'b0, 1'b0, 1'b1);
      k = 0;
      while (done !== 1'b1 && k < 30) begin @(negedge Clock); k++; end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL draw_done got=%b want=1", done); end
      total++; if (dhand !== 5'd17) begin bad++; $display("[TB] FAIL draw_dealer got=%0d want=17", dhand); end
      total++; if (result !== 4'b1010) begin bad++; $display("[TB] FAIL draw_result got=%b want=1010", result); end
      pulse_at(5, 1'b0, 1'b1, 1'b0);
      total++; if (phand !== {5'd12, 5'd10}) begin bad++; $display("[TB] FAIL done_hit_ignored got=%h want=%h", phand, {5'd12, 5'd10}); end
   endtask

   // P0 hits 10 (20) then 5 (25, bust, auto-advance); P1 stands at 12;
   // dealer enters on card 7: 8+7=15, +8=23 bust.
   task automatic test_bust();
      int k;
      pulse_at(3, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge Clock);
      pulse_at(10, 1'b0, 1'b1, 1'b0);
      total++; if (phand[4:0] !== 5'd20) begin bad++; $display("[TB] FAIL hit_p0 got=%0d want=20", phand[4:0]); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL hit_active got=%0d want=0", active_player); end
      pulse_at(5, 1'b0, 1'b1, 1'b0);
      total++; if (phand[4:0] !== 5'd25) begin bad++; $display("[TB] FAIL bust_p0 got=%0d want=25", phand[4:0]); end
      total++; if (active_player !== 1'b1) begin bad++; $display("[TB] FAIL bust_advance got=%0d want=1", active_player); end
      pulse_at(6, 1'b0, 1'b0, 1'b1);
      k = 0;
      while (done !== 1'b1 && k < 30) begin @(negedge Clock); k++; end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL bust_done got=%b want=1", done); end
      total++; if (dhand !== 5'd23) begin bad++; $display("[TB] FAIL bust_dealer got=%0d want=23", dhand); end
      total++; if (result !== 4'b0110) begin bad++; $display("[TB] FAIL bust_result got=%b want=0110", result); end
   endtask

   // Start ignored mid-turn; hit+stand together -> no card, turn advances.
   task automatic test_simultaneous();
      pulse_at(3, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge Clock);
      pulse_at(10, 1'b1, 1'b0, 1'b0);
      total++; if (phand !== {5'd12, 5'd10}) begin bad++; $display("[TB] FAIL start_ignored_hands got=%h want=%h", phand, {5'd12, 5'd10}); end
      total++; if (dhand !== 5'd8) begin bad++; $display("[TB] FAIL start_ignored_dealer got=%0d want=8", dhand); end
      pulse_at(2, 1'b0, 1'b1, 1'b1);
      total++; if (phand[4:0] !== 5'd10) begin bad++; $display("[TB] FAIL simul_p0 got=%0d want=10", phand[4:0]); end
      total++; if (active_player !== 1'b1) begin bad++; $display("[TB] FAIL simul_active got=%0d want=1", active_player); end
   endtask

   // Reset in the first dealer-turn cycle, then a clean round.
   task automatic test_reset_mid_round();
      pulse_at(5, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      @(negedge Clock);
      total++; if (phand !== 10'd0) begin bad++; $display("[TB] FAIL abort_phand got=%0d want=0", phand); end
      total++; if (dhand !== 5'd0) begin bad++; $display("[TB] FAIL abort_dhand got=%0d want=0", dhand); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL abort_active got=%0d want=0", active_player); end
      total++; if ({result, done} !== 5'd0) begin bad++; $display("[TB] FAIL abort_result got=%b want=00000", {result, done}); end
      reset = 1'b0;
      pulse_at(2, 1'b0, 1'b1, 1'b0);
      total++; if (phand !== 10'd0) begin bad++; $display("[TB] FAIL idle_hit_ignored got=%0d want=0", phand); end
      pulse_at(3, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge Clock);
      total++; if (phand !== {5'd12, 5'd10}) begin bad++; $display("[TB] FAIL clean_hands got=%h want=%h", phand, {5'd12, 5'd10}); end
      total++; if (dhand !== 5'd8) begin bad++; $display("[TB] FAIL clean_dealer got=%0d want=8", dhand); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL clean_active got=%0d want=0", active_player); end
   endtask

   // Start at card 1: deal 2..6 -> P0=6, P1=8, dealer=6. P0 draws 1 then 8.
   task automatic test_soft_ace();
      logic [4:0] want_ace;
`ifdef BLACKJACK_SOFT_ACE_EN
      want_ace = 5'd17;
`else
      want_ace = 5'd7;
`endif
      reset = 1'b1;
      @(negedge Clock);
      reset = 1'b0;
      pulse_at(1, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge Clock);
      total++; if (phand !== {5'd8, 5'd6}) begin bad++; $display("[TB] FAIL soft_deal got=%h want=%h", phand, {5'd8, 5'd6}); end
      pulse_at(1, 1'b0, 1'b1, 1'b0);
      total++; if (phand[4:0] !== want_ace) begin bad++; $display("[TB] FAIL ace_draw got=%0d want=%0d", phand[4:0], want_ace); end
      pulse_at(8, 1'b0, 1'b1, 1'b0);
      total++; if (phand[4:0] !== 5'd15) begin bad++; $display("[TB] FAIL ace_then_8 got=%0d want=15", phand[4:0]); end
      total++; if (active_player !== 1'b0) begin bad++; $display("[TB] FAIL ace_active got=%0d want=0", active_player); end
   endtask

   // P0 15+7=22 bust; P1 8+10=18, +9=27 bust -> dealer must not draw.
   task automatic test_all_bust();
      int k;
      pulse_at(7, 1'b0, 1'b1, 1'b0);
      total++; if (active_player !== 1'b1) begin bad++; $display("[TB] FAIL allbust_advance got=%0d want=1", active_player); end
      pulse_at(10, 1'b0, 1'b1, 1'b0);
      pulse_at(9, 1'b0, 1'b1, 1'b0);
      k = 0;
      while (done !== 1'b1 && k < 30) begin @(negedge Clock); k++; end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL allbust_done got=%b want=1", done); end
      total++; if (phand !== {5'd27, 5'd22}) begin bad++; $display("[TB] FAIL allbust_hands got=%h want=%h", phand, {5'd27, 5'd22}); end
      total++; if (dhand !== 5'd6) begin bad++; $display("[TB] FAIL allbust_dealer got=%0d want=6", dhand); end
      total++; if (result !== 4'b1010) begin bad++; $display("[TB] FAIL allbust_result got=%b want=1010", result); end
   endtask

   initial begin
      test_reset();
      test_deal();
      test_dealer_draw();
      test_bust();
      test_simultaneous();
      test_reset_mid_round();
      test_soft_ace();
      test_all_bust();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

endmodule
